// File: rtl/alu_operand_sequencer_if.sv
// Signal bundle between the operand sequencer and its board/ALU surroundings.
// The master side is the sequencer; the slave side is the switches, buttons and ALU.
interface alu_operand_sequencer_if #(
   parameter int N = 8
);
   logic [N-1:0] data_in;
   logic         enter;
   logic         btn_up;
   logic         btn_down;
   logic         btn_right;
   logic         btn_left;
   logic [N-1:0] alu_result;
   logic [3:0]   alu_status;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic [3:0]   opcode;
   logic [N-1:0] display_value;
   logic         result_valid;
   logic         status_err;
   logic [3:0]   state_leds;

   modport master (
      input  data_in, enter, btn_up, btn_down, btn_right, btn_left,
      input  alu_result, alu_status,
      output A, B, opcode, display_value, result_valid, status_err, state_leds
   );

   modport slave (
      output data_in, enter, btn_up, btn_down, btn_right, btn_left,
      output alu_result, alu_status,
      input  A, B, opcode, display_value, result_valid, status_err, state_leds
   );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Operand/opcode sequencer for the one-hot ALU: captures A, B and an operation from
// switches and buttons, then latches the ALU result and checks its status echo.
module alu_operand_sequencer #(
   parameter int N = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   alu_operand_sequencer_if.master   bus
);

   // State values double as the one-hot LED pattern.
   typedef enum logic [3:0] {
      GET_A  = 4'b0001,
      GET_B  = 4'b0010,
      GET_OP = 4'b0100,
      SHOW   = 4'b1000
   } state_t;

   state_t       state_reg;
   logic         enter_prev_reg;
   logic [3:0]   dir_prev_reg;
   logic [N-1:0] a_reg;
   logic [N-1:0] b_reg;
   logic [N-1:0] result_reg;
   logic [3:0]   opcode_reg;
   logic         valid_reg;
   logic         err_reg;
   logic         pending_reg;

   logic [3:0]   dir_level;
   logic [3:0]   dir_press;
   logic         enter_press;
   logic         dir_single;
   logic [N-1:0] display_next;

   // Bit order matches the opcode encoding: up=1000, down=0100, right=0010, left=0001.
   assign dir_level = {bus.btn_up, bus.btn_down, bus.btn_right, bus.btn_left};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_dir_edge
         assign dir_press[gi] = dir_level[gi] & ~dir_prev_reg[gi];
      end
   endgenerate

   assign enter_press = bus.enter & ~enter_prev_reg;
   assign dir_single  = (dir_press != 4'd0) && ((dir_press & (dir_press - 4'd1)) == 4'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= GET_A;
         enter_prev_reg <= 1'b1;
         dir_prev_reg   <= 4'b1111;
         a_reg          <= '0;
         b_reg          <= '0;
         result_reg     <= '0;
         opcode_reg     <= 4'd0;
         valid_reg      <= 1'b0;
         err_reg        <= 1'b0;
         pending_reg    <= 1'b0;
      end else begin
         enter_prev_reg <= bus.enter;
         dir_prev_reg   <= dir_level;
         case (state_reg)
            GET_A: begin
               if (enter_press) begin
                  a_reg     <= bus.data_in;
                  state_reg <= GET_B;
               end
            end
            GET_B: begin
               if (enter_press) begin
                  b_reg     <= bus.data_in;
                  state_reg <= GET_OP;
               end
            end
            GET_OP: begin
               if (dir_single) begin
                  opcode_reg  <= dir_press;
                  pending_reg <= 1'b1;
                  state_reg   <= SHOW;
               end
            end
            SHOW: begin
               // Enter beats a simultaneous direction press; a new opcode beats a capture.
               if (enter_press) begin
                  state_reg   <= GET_A;
                  opcode_reg  <= 4'd0;
                  valid_reg   <= 1'b0;
                  err_reg     <= 1'b0;
                  pending_reg <= 1'b0;
               end else if (dir_single) begin
                  opcode_reg  <= dir_press;
                  valid_reg   <= 1'b0;
                  pending_reg <= 1'b1;
               end else if (pending_reg) begin
                  result_reg  <= bus.alu_result;
                  valid_reg   <= 1'b1;
                  err_reg     <= (bus.alu_status != opcode_reg);
                  pending_reg <= 1'b0;
               end
            end
            default: state_reg <= GET_A;
         endcase
      end
   end

   always_comb begin
      display_next = '0;
      case (state_reg)
         GET_A, GET_B: display_next = bus.data_in;
         GET_OP:       display_next = b_reg;
         SHOW:         display_next = valid_reg ? result_reg : '0;
         default:      display_next = '0;
      endcase
   end

   assign bus.A             = a_reg;
   assign bus.B             = b_reg;
   assign bus.opcode        = opcode_reg;
   assign bus.display_value = display_next;
   assign bus.result_valid  = valid_reg;
   assign bus.status_err    = err_reg;
   assign bus.state_leds    = state_reg;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: a simple ALU stand-in, a transaction-level model
// checked on every falling edge, directed scenarios with literal expectations, then random traffic.
module tb_alu_operand_sequencer;

   localparam int N = 8;

   logic clk;
   logic reset;
   logic force_bad;
   bit   started;
   int   checks;
   int   errors;

   alu_operand_sequencer_if #(.N(N)) bus ();

   alu_operand_sequencer #(.N(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU stand-in; force_bad makes it report an all-zero status.
   always_comb begin
      case (bus.opcode)
         4'b1000: bus.alu_result = bus.A + bus.B;
         4'b0100: bus.alu_result = bus.A - bus.B;
         4'b0010: bus.alu_result = bus.A | bus.B;
         4'b0001: bus.alu_result = bus.A & bus.B;
         default: bus.alu_result = '0;
      endcase
      bus.alu_status = force_bad ? 4'b0000 : bus.opcode;
   end

   typedef struct packed {
      int       phase;   // 0=A entry, 1=B entry, 2=operation choice, 3=result shown
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] op;
      logic [7:0] res;
      logic       valid;
      logic       err;
      logic       pend;
      logic [4:0] prev;  // {enter, up, down, right, left} levels seen last cycle
   } model_t;

   model_t m;

   function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op);
      int ia;
      int ib;
      ia = int'(a);
      ib = int'(b);
      case (op)
         4'b1000: return 8'((ia + ib) % 256);
         4'b0100: return 8'((ia - ib + 256) % 256);
         4'b0010: return a | b;
         4'b0001: return a & b;
         default: return 8'd0;
      endcase
   endfunction

   function automatic model_t model_next(input model_t s, input logic rst,
                                         input logic [7:0] din, input logic ent,
                                         input logic [3:0] dir, input logic bad);
      model_t n;
      logic       ent_rise;
      logic [3:0] rises;
      int         nrise;
      n = s;
      if (rst) begin
         n = '0;
         n.prev = 5'b11111;
         return n;
      end
      ent_rise = ent && !s.prev[4];
      rises    = dir & ~s.prev[3:0];
      nrise    = $countones(rises);
      n.prev   = {ent, dir};
      if (s.phase == 0 && ent_rise) begin
         n.a = din;
         n.phase = 1;
      end else if (s.phase == 1 && ent_rise) begin
         n.b = din;
         n.phase = 2;
      end else if (s.phase == 2 && nrise == 1) begin
         n.op = rises;
         n.pend = 1'b1;
         n.phase = 3;
      end else if (s.phase == 3) begin
         if (ent_rise) begin
            n.phase = 0;
            n.op = 4'd0;
            n.valid = 1'b0;
            n.err = 1'b0;
            n.pend = 1'b0;
         end else if (nrise == 1) begin
            n.op = rises;
            n.valid = 1'b0;
            n.pend = 1'b1;
         end else if (s.pend) begin
            n.res = alu_ref(s.a, s.b, s.op);
            n.valid = 1'b1;
            n.err = bad;   // a zero status never equals a loaded one-hot opcode
            n.pend = 1'b0;
         end
      end
      return n;
   endfunction

   always @(posedge clk)
      m <= model_next(m, reset, bus.data_in, bus.enter,
                      {bus.btn_up, bus.btn_down, bus.btn_right, bus.btn_left}, force_bad);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         logic [7:0] exp_disp;
         case (m.phase)
            0, 1:    exp_disp = bus.data_in;
            2:       exp_disp = m.b;
            default: exp_disp = m.valid ? m.res : 8'd0;
         endcase
         chk("model_state_leds", 32'(bus.state_leds), 32'(4'b0001 << m.phase));
         chk("model_A", 32'(bus.A), 32'(m.a));
         chk("model_B", 32'(bus.B), 32'(m.b));
         chk("model_opcode", 32'(bus.opcode), 32'(m.op));
         chk("model_result_valid", 32'(bus.result_valid), 32'(m.valid));
         chk("model_status_err", 32'(bus.status_err), 32'(m.err));
         chk("model_display", 32'(bus.display_value), 32'(exp_disp));
         $display("cyc t=%0t rst=%0b din=%h ent=%0b dir=%b leds=%b A=%h B=%h op=%b disp=%h v=%0b err=%0b",
                  $time, reset, bus.data_in, bus.enter,
                  {bus.btn_up, bus.btn_down, bus.btn_right, bus.btn_left},
                  bus.state_leds, bus.A, bus.B, bus.opcode, bus.display_value,
                  bus.result_valid, bus.status_err);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_dir(input logic [3:0] d);
      bus.btn_up    = d[3];
      bus.btn_down  = d[2];
      bus.btn_right = d[1];
      bus.btn_left  = d[0];
   endtask

   task automatic press_enter(input logic [7:0] din);
      bus.data_in = din;
      bus.enter   = 1'b1;
      tick();
      bus.enter   = 1'b0;
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      started = 1'b0;
      reset = 1'b1;
      force_bad = 1'b0;
      bus.data_in = '0;
      bus.enter = 1'b0;
      set_dir(4'b0000);
      tick();
      tick();
      started = 1'b1;
      chk("reset_leds", 32'(bus.state_leds), 32'h1);
      chk("reset_opcode", 32'(bus.opcode), 32'h0);
      reset = 1'b0;
      tick();

      // Scenario 1: 5 + 3
      press_enter(8'h05);
      press_enter(8'h03);
      set_dir(4'b1000);
      tick();
      chk("s1_opcode", 32'(bus.opcode), 32'h8);
      chk("s1_valid_before", 32'(bus.result_valid), 32'h0);
      set_dir(4'b0000);
      tick();
      chk("s1_valid", 32'(bus.result_valid), 32'h1);
      chk("s1_display", 32'(bus.display_value), 32'h08);
      chk("s1_err", 32'(bus.status_err), 32'h0);

      // Scenario 2: 3 - 5 wraps, then reload with AND
      press_enter(8'h00);
      press_enter(8'h03);
      press_enter(8'h05);
      set_dir(4'b0100);
      tick();
      set_dir(4'b0000);
      tick();
      chk("s2_display_sub", 32'(bus.display_value), 32'hFE);
      chk("s2_err", 32'(bus.status_err), 32'h0);
      set_dir(4'b0001);
      tick();
      chk("s2_reload_valid", 32'(bus.result_valid), 32'h0);
      set_dir(4'b0000);
      tick();
      chk("s2_and_valid", 32'(bus.result_valid), 32'h1);
      chk("s2_and_display", 32'(bus.display_value), 32'h01);

      // Scenario 3: two simultaneous presses are ignored
      press_enter(8'h00);
      press_enter(8'h07);
      press_enter(8'h09);
      set_dir(4'b1010);
      tick();
      chk("s3_double_leds", 32'(bus.state_leds), 32'h4);
      chk("s3_double_opcode", 32'(bus.opcode), 32'h0);
      set_dir(4'b0000);
      tick();
      set_dir(4'b0010);
      tick();
      chk("s3_right_opcode", 32'(bus.opcode), 32'h2);
      set_dir(4'b0000);
      tick();

      // Scenario 4: enter held through reset gives no edge
      reset = 1'b1;
      bus.enter = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk("s4_held_leds", 32'(bus.state_leds), 32'h1);
      bus.enter = 1'b0;
      tick();
      bus.enter = 1'b1;
      tick();
      chk("s4_press_leds", 32'(bus.state_leds), 32'h2);
      bus.enter = 1'b0;
      tick();

      // Scenario 5: bad status echo
      press_enter(8'h11);
      set_dir(4'b1000);
      tick();
      set_dir(4'b0000);
      force_bad = 1'b1;
      tick();
      chk("s5_err", 32'(bus.status_err), 32'h1);
      force_bad = 1'b0;
      bus.enter = 1'b1;
      tick();
      chk("s5_exit_leds", 32'(bus.state_leds), 32'h1);
      chk("s5_exit_err", 32'(bus.status_err), 32'h0);
      bus.enter = 1'b0;
      tick();

      // Scenario 6: reset while showing a result
      press_enter(8'h02);
      press_enter(8'h04);
      set_dir(4'b0010);
      tick();
      set_dir(4'b0000);
      tick();
      chk("s6_valid_before", 32'(bus.result_valid), 32'h1);
      reset = 1'b1;
      tick();
      chk("s6_leds", 32'(bus.state_leds), 32'h1);
      chk("s6_A", 32'(bus.A), 32'h0);
      chk("s6_B", 32'(bus.B), 32'h0);
      chk("s6_valid", 32'(bus.result_valid), 32'h0);
      reset = 1'b0;
      tick();

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         reset       = ($urandom_range(0, 199) == 0);
         bus.data_in = 8'($urandom);
         bus.enter   = ($urandom_range(0, 4) == 0);
         set_dir({($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)});
         force_bad   = ($urandom_range(0, 3) == 0);
         tick();
      end

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
